// File: rtl/telemetry_pkg.sv
// rtl/telemetry_pkg.sv - shared constants and types for the telemetry frame controller
package telemetry_pkg;

    localparam int FRAME_BYTES = 8;

    localparam int CPU_OFS  = 0;
    localparam int DISK_OFS = 2;
    localparam int MEM_OFS  = 4;
    localparam int TEMP_OFS = 6;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LAUNCH     = 2'd1,
        WAIT_SCORE = 2'd2,
        REPORT     = 2'd3
    } frame_state_t;

    typedef struct packed {
        logic [15:0] cpu;
        logic [15:0] disk;
        logic [15:0] mem;
        logic [15:0] temp;
    } telem_fields_t;

endpackage

// File: rtl/telem_byte_timer.sv
// rtl/telem_byte_timer.sv - inter-byte idle timer, built only with TELEM_BYTE_TIMEOUT_EN
module telem_byte_timer #(
    parameter int BYTE_TIMEOUT = 104_200
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(BYTE_TIMEOUT + 1);

    logic [CNT_W-1:0] count;

    assign expired = en && (count == CNT_W'(BYTE_TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst || clr || expired) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/telemetry_frame_ctrl.sv
// rtl/telemetry_frame_ctrl.sv - UART byte assembler and scoring sequencer; optional TELEM_BYTE_TIMEOUT_EN
module telemetry_frame_ctrl
    import telemetry_pkg::*;
#(
    parameter int BYTE_TIMEOUT = 104_200,
    parameter int TEMP_LIMIT   = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_busy,
    input  logic [31:0] score,
    input  logic        score_valid,
    output logic [15:0] cpu_freq_mhz,
    output logic [15:0] disk_speed_mbps,
    output logic [15:0] memory_usage,
    output logic [15:0] temperature_c,
    output logic        compute_enable,
    output logic [31:0] score_out,
    output logic        result_valid,
    output logic        temp_alarm,
    output logic [7:0]  frame_err_cnt,
    output logic [7:0]  overrun_cnt
);

    localparam int IDX_W = $clog2(FRAME_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

    logic               prev_rx_busy;
    logic               byte_strobe;
    logic               frame_done;
    logic               timeout_hit;
    logic [IDX_W-1:0]   idx;
    logic [7:0]         byte_buf [0:FRAME_BYTES-2];
    frame_state_t       state, state_next;
    telem_fields_t      fields, frame_fields;

    assign byte_strobe = prev_rx_busy && !rx_busy;
    assign frame_done  = byte_strobe && (idx == LAST_IDX);

    // The last byte bypasses the buffer so fields latch on the completing strobe itself
    assign frame_fields.cpu  = {byte_buf[CPU_OFS+1],  byte_buf[CPU_OFS]};
    assign frame_fields.disk = {byte_buf[DISK_OFS+1], byte_buf[DISK_OFS]};
    assign frame_fields.mem  = {byte_buf[MEM_OFS+1],  byte_buf[MEM_OFS]};
    assign frame_fields.temp = {rx_data,              byte_buf[TEMP_OFS]};

`ifdef TELEM_BYTE_TIMEOUT_EN
    logic timer_expired;

    telem_byte_timer #(
        .BYTE_TIMEOUT(BYTE_TIMEOUT)
    ) u_byte_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (byte_strobe),
        .en      (idx != '0),
        .expired (timer_expired)
    );

    assign timeout_hit = timer_expired && !byte_strobe;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err_cnt <= '0;
        end else if (timeout_hit && frame_err_cnt != 8'hFF) begin
            frame_err_cnt <= frame_err_cnt + 8'd1;
        end
    end
`else
    assign timeout_hit   = 1'b0;
    assign frame_err_cnt = '0;
`endif

    always_ff @(posedge clk) begin
        if (byte_strobe && !frame_done) begin
            byte_buf[idx] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_rx_busy <= 1'b0;
            idx          <= '0;
            state        <= IDLE;
            fields       <= '0;
            temp_alarm   <= 1'b0;
            score_out    <= '0;
            overrun_cnt  <= '0;
        end else begin
            prev_rx_busy <= rx_busy;
            state        <= state_next;
            if (byte_strobe) begin
                idx <= frame_done ? '0 : idx + 1'b1;
            end else if (timeout_hit) begin
                idx <= '0;
            end
            if (frame_done && state == IDLE) begin
                fields     <= frame_fields;
                temp_alarm <= (frame_fields.temp >= 16'(TEMP_LIMIT));
            end
            if (frame_done && state != IDLE && overrun_cnt != 8'hFF) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
            if (state == WAIT_SCORE && score_valid) begin
                score_out <= score;
            end
        end
    end

    always_comb begin
        state_next     = state;
        compute_enable = 1'b0;
        result_valid   = 1'b0;
        case (state)
            IDLE:       if (frame_done) state_next = LAUNCH;
            LAUNCH: begin
                compute_enable = 1'b1;
                state_next     = WAIT_SCORE;
            end
            WAIT_SCORE: if (score_valid) state_next = REPORT;
            REPORT: begin
                result_valid = 1'b1;
                state_next   = IDLE;
            end
            default:    state_next = IDLE;
        endcase
    end

    assign cpu_freq_mhz    = fields.cpu;
    assign disk_speed_mbps = fields.disk;
    assign memory_usage    = fields.mem;
    assign temperature_c   = fields.temp;

endmodule

// File: tb/tb_telemetry_frame_ctrl.sv
// tb/tb_telemetry_frame_ctrl.sv - scoreboard bench for telemetry_frame_ctrl
module tb_telemetry_frame_ctrl;

    localparam int TB_TIMEOUT = 300;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_busy = 1'b0;
    logic [31:0] score = '0;
    logic        score_valid = 1'b0;
    logic [15:0] cpu_freq_mhz, disk_speed_mbps, memory_usage, temperature_c;
    logic        compute_enable, result_valid, temp_alarm;
    logic [31:0] score_out;
    logic [7:0]  frame_err_cnt, overrun_cnt;

    telemetry_frame_ctrl #(
        .BYTE_TIMEOUT(TB_TIMEOUT),
        .TEMP_LIMIT  (100)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rx_data         (rx_data),
        .rx_busy         (rx_busy),
        .score           (score),
        .score_valid     (score_valid),
        .cpu_freq_mhz    (cpu_freq_mhz),
        .disk_speed_mbps (disk_speed_mbps),
        .memory_usage    (memory_usage),
        .temperature_c   (temperature_c),
        .compute_enable  (compute_enable),
        .score_out       (score_out),
        .result_valid    (result_valid),
        .temp_alarm      (temp_alarm),
        .frame_err_cnt   (frame_err_cnt),
        .overrun_cnt     (overrun_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] cpu;
        logic [15:0] disk;
        logic [15:0] mem;
        logic [15:0] temp;
        logic        alarm;
    } exp_frame_t;

    exp_frame_t  exp_q[$];
    logic [31:0] score_q[$];
    int n_cmp = 0, n_err = 0;
    int n_launch = 0, n_result = 0;
    int exp_launch = 0, exp_result = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_busy = 1'b1;
        tick(3);
        rx_busy = 1'b0;
        tick(2);
    endtask

    // Frame words hold byte 0 in the low octet
    task automatic send_range(input logic [63:0] f, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send_byte(f[8*i +: 8]);
    endtask

    task automatic push_exp(input logic [15:0] c, input logic [15:0] d, input logic [15:0] m,
                            input logic [15:0] t, input logic a);
        exp_frame_t e;
        e.cpu = c; e.disk = d; e.mem = m; e.temp = t; e.alarm = a;
        exp_q.push_back(e);
        exp_launch++;
    endtask

    task automatic respond(input logic [31:0] s);
        score       = s;
        score_valid = 1'b1;
        score_q.push_back(s);
        exp_result++;
        tick(1);
        score_valid = 1'b0;
        tick(2);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cpu"},  cpu_freq_mhz, 0);
        check({tag, "_disk"}, disk_speed_mbps, 0);
        check({tag, "_mem"},  memory_usage, 0);
        check({tag, "_temp"}, temperature_c, 0);
        check({tag, "_ce"},   compute_enable, 0);
        check({tag, "_rv"},   result_valid, 0);
        check({tag, "_sc"},   score_out, 0);
        check({tag, "_alm"},  temp_alarm, 0);
        check({tag, "_ferr"}, frame_err_cnt, 0);
        check({tag, "_ovr"},  overrun_cnt, 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (compute_enable) begin
                n_launch++;
                if (exp_q.size() > 0) begin
                    exp_frame_t e;
                    e = exp_q.pop_front();
                    check("cpu",   cpu_freq_mhz,    e.cpu);
                    check("disk",  disk_speed_mbps, e.disk);
                    check("mem",   memory_usage,    e.mem);
                    check("temp",  temperature_c,   e.temp);
                    check("alarm", temp_alarm,      e.alarm);
                end
            end
            if (result_valid) begin
                n_result++;
                if (score_q.size() > 0) check("score_out", score_out, score_q.pop_front());
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tick(3);
        check_all_zero("reset");
        rst = 1'b0;
        tick(2);

        push_exp(4500, 2000, 16384, 70, 1'b0);
        send_range(64'h0046_4000_07D0_1194, 0, 7);
        respond(32'd12345);
        check("hold_cpu", cpu_freq_mhz, 4500);

        score       = 32'hDEAD_BEEF;
        score_valid = 1'b1;
        tick(1);
        score_valid = 1'b0;
        tick(3);
        check("stray_score_out", score_out, 32'd12345);

        push_exp(3400, 550, 16384, 105, 1'b1);
        send_range(64'h0069_4000_0226_0D48, 0, 7);
        respond(32'd9876);
        push_exp(0, 0, 0, 255, 1'b1);
        send_range(64'h00FF_0000_0000_0000, 0, 7);
        respond(32'hFFFF_FFFF);

        push_exp(513, 1027, 1541, 2055, 1'b1);
        send_range(64'h0807_0605_0403_0201, 0, 7);
        send_range(64'h0011_2233_4455_6677, 0, 7);
        check("overrun_one", overrun_cnt, 1);
        check("overrun_hold_cpu", cpu_freq_mhz, 513);
        for (int k = 0; k < 255; k++) send_range(64'h0011_2233_4455_6677, 0, 7);
        check("overrun_sat", overrun_cnt, 255);
        check("overrun_hold_temp", temperature_c, 2055);
        respond(32'd42);

        send_range(64'h0011_2233_4455_6677, 0, 4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_all_zero("midreset");
        push_exp(3, 2, 1, 100, 1'b1);
        send_range(64'h0064_0001_0002_0003, 0, 7);
        respond(32'd100);

        push_exp(0, 0, 0, 99, 1'b0);
        send_range(64'h0063_0000_0000_0000, 0, 7);
        send_range(64'h0123_4567_89AB_CDEF, 0, 6);
        rx_data = 8'h01;
        rx_busy = 1'b1;
        tick(3);
        rx_busy     = 1'b0;
        score       = 32'd777;
        score_valid = 1'b1;
        score_q.push_back(32'd777);
        exp_result++;
        tick(1);
        score_valid = 1'b0;
        tick(3);
        check("simul_overrun", overrun_cnt, 1);
        check("simul_hold_temp", temperature_c, 99);

`ifdef TELEM_BYTE_TIMEOUT_EN
        send_range(64'h0011_2233_4455_6677, 0, 2);
        tick(2 * TB_TIMEOUT);
        check("frame_err", frame_err_cnt, 1);
        push_exp(3000, 1000, 2048, 50, 1'b0);
        send_range(64'h0032_0800_03E8_0BB8, 0, 7);
        respond(32'd555);
`else
        push_exp(3000, 1000, 2048, 50, 1'b0);
        send_range(64'h0032_0800_03E8_0BB8, 0, 2);
        tick(2 * TB_TIMEOUT);
        send_range(64'h0032_0800_03E8_0BB8, 3, 7);
        respond(32'd555);
        check("frame_err_off", frame_err_cnt, 0);
`endif

        tick(4);
        check("launch_cnt", n_launch, exp_launch);
        check("result_cnt", n_result, exp_result);
        check("exp_q_left", exp_q.size(), 0);
        check("score_q_left", score_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
